// File: rtl/conv_ch_accum.sv
// Multi-channel convolution accumulator.
// An input register, a product stage, a window-sum stage and an accumulate/output
// stage. A channel counter tags beats first/last so that partial sums over
// several input channels collapse into one biased, ReLU'd, saturated result.
module conv_ch_accum #(
    parameter int MULT   = 0,
    parameter int useCLA = 0,
    parameter int KERNEL = 3,
    parameter int N      = 4,
    parameter int M      = 4,
    parameter int E      = 4,
    parameter int CH_MAX = 4,
    parameter int CE     = 2,
    parameter int SIGNED = 0,
    parameter int OUT_W  = 8,
    localparam int ACC_W = N + M + E + CE + 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [KERNEL*KERNEL*N-1:0]      data2conv,
    input  logic [KERNEL*KERNEL*M-1:0]      w,
    input  logic                            en_in,
    output logic                            in_ready,
    input  logic [CE:0]                     cfg_ch,
    input  logic                            cfg_relu,
    input  logic signed [ACC_W-1:0]         bias,
    output logic [OUT_W-1:0]                d_out,
    output logic                            en_out,
    input  logic                            out_ready
);
    localparam int K2  = KERNEL * KERNEL;
    localparam int P_W = N + M;
    localparam int S_W = N + M + E;
    localparam int R_W = ACC_W + 1;
    localparam logic signed [R_W-1:0] HI = (SIGNED != 0) ? R_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1)
                                                         : R_W'((64'sd1 <<< OUT_W) - 64'sd1);
    localparam logic signed [R_W-1:0] LO = (SIGNED != 0) ? R_W'(-(64'sd1 <<< (OUT_W - 1)))
                                                         : R_W'(64'sd0);

    // Window-sum adders: bit-level ripple or flattened lookahead carries.
    function automatic logic [S_W-1:0] add_rca(input logic [S_W-1:0] a, input logic [S_W-1:0] b);
        logic [S_W-1:0] s;
        logic c;
        c = 1'b0;
        for (int i = 0; i < S_W; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        return s;
    endfunction

    function automatic logic [S_W-1:0] add_cla(input logic [S_W-1:0] a, input logic [S_W-1:0] b);
        logic [S_W-1:0] g, p;
        logic [S_W:0]   c;
        logic           t;
        g = a & b;
        p = a ^ b;
        c = '0;
        for (int i = 0; i < S_W; i++) begin
            c[i+1] = g[i];
            t      = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (t & g[j]);
                t      = t & p[j];
            end
        end
        return p ^ c[S_W-1:0];
    endfunction

    function automatic logic [S_W-1:0] add_w(input logic [S_W-1:0] a, input logic [S_W-1:0] b);
        if (useCLA != 0) return add_cla(a, b);
        else             return add_rca(a, b);
    endfunction

    // Shift-and-add multiplier with a full-adder row per partial product.
    function automatic logic [P_W-1:0] mul_fa(input logic [P_W-1:0] a, input logic [P_W-1:0] b);
        logic [P_W-1:0] acc, pp;
        logic s, c;
        acc = '0;
        for (int i = 0; i < P_W; i++) begin
            pp = b[i] ? (a << i) : '0;
            c  = 1'b0;
            for (int j = 0; j < P_W; j++) begin
                s      = acc[j] ^ pp[j] ^ c;
                c      = (acc[j] & pp[j]) | (c & (acc[j] ^ pp[j]));
                acc[j] = s;
            end
        end
        return acc;
    endfunction

    function automatic logic [P_W-1:0] ext_d(input logic [N-1:0] x);
        if (SIGNED != 0) return P_W'($signed(x));
        else             return P_W'(x);
    endfunction

    function automatic logic [P_W-1:0] ext_w(input logic [M-1:0] x);
        if (SIGNED != 0) return P_W'($signed(x));
        else             return P_W'(x);
    endfunction

    function automatic logic [S_W-1:0] ext_p(input logic [P_W-1:0] x);
        if (SIGNED != 0) return S_W'($signed(x));
        else             return S_W'(x);
    endfunction

    logic stall, adv, take;
    assign stall    = en_out & ~out_ready;
    assign adv      = ~stall;
    assign in_ready = adv;
    assign take     = en_in & adv;

    logic [CE:0] cnt, ch_reg, ch_cfg, ch_now;
    logic        relu_reg, first_in, last_in, relu_now;

    // Clamp the requested channel count into 1..CH_MAX.
    always_comb begin
        ch_cfg = cfg_ch;
        if (cfg_ch == '0)                         ch_cfg = (CE+1)'(1);
        else if (cfg_ch > (CE+1)'(CH_MAX))        ch_cfg = (CE+1)'(CH_MAX);
    end

    assign first_in = (cnt == '0);
    assign ch_now   = first_in ? ch_cfg : ch_reg;
    assign last_in  = ((cnt + (CE+1)'(1)) == ch_now);
    assign relu_now = first_in ? cfg_relu : relu_reg;

    // Channel counter; config is latched on the first beat of every output.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt      <= '0;
            ch_reg   <= '0;
            relu_reg <= 1'b0;
        end else if (take) begin
            cnt <= last_in ? '0 : cnt + (CE+1)'(1);
            if (first_in) begin
                ch_reg   <= ch_cfg;
                relu_reg <= cfg_relu;
            end
        end
    end

    logic [K2*N-1:0]          d0;
    logic [K2*M-1:0]          w0;
    logic                     v0, f0, l0, relu0;
    logic signed [ACC_W-1:0]  b0;

    // Input register: captures the accepted beat and its tags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            v0 <= 1'b0; f0 <= 1'b0; l0 <= 1'b0; relu0 <= 1'b0;
            d0 <= '0; w0 <= '0; b0 <= '0;
        end else if (adv) begin
            v0 <= en_in;
            if (en_in) begin
                d0 <= data2conv; w0 <= w;
                f0 <= first_in; l0 <= last_in; relu0 <= relu_now; b0 <= bias;
            end
        end
    end

    logic [K2-1:0][P_W-1:0] prod, p1;
    logic                   v1, f1, l1, relu1;
    logic signed [ACC_W-1:0] b1;

    for (genvar gi = 0; gi < K2; gi++) begin : g_mul
        logic [P_W-1:0] a, b;
        assign a = ext_d(d0[gi*N +: N]);
        assign b = ext_w(w0[gi*M +: M]);
        if (MULT != 0) begin : g_fa
            assign prod[gi] = mul_fa(a, b);
        end else begin : g_op
            assign prod[gi] = a * b;
        end
    end

    // Stage 1: register the per-tap products.
    always_ff @(posedge clk) begin
        if (!rst) begin
            v1 <= 1'b0; f1 <= 1'b0; l1 <= 1'b0; relu1 <= 1'b0;
            p1 <= '0; b1 <= '0;
        end else if (adv) begin
            v1 <= v0; f1 <= f0; l1 <= l0; relu1 <= relu0;
            p1 <= prod; b1 <= b0;
        end
    end

    logic [S_W-1:0]          wsum, s2;
    logic                    v2, f2, l2, relu2;
    logic signed [ACC_W-1:0] b2;

    // Reduce the products into the window sum; E guard bits keep it exact.
    always_comb begin
        wsum = '0;
        for (int i = 0; i < K2; i++) wsum = add_w(wsum, ext_p(p1[i]));
    end

    // Stage 2: register the window sum.
    always_ff @(posedge clk) begin
        if (!rst) begin
            v2 <= 1'b0; f2 <= 1'b0; l2 <= 1'b0; relu2 <= 1'b0;
            s2 <= '0; b2 <= '0;
        end else if (adv) begin
            v2 <= v1; f2 <= f1; l2 <= l1; relu2 <= relu1;
            s2 <= wsum; b2 <= b1;
        end
    end

    logic signed [ACC_W-1:0] acc, s2_x, acc_sum;
    logic signed [R_W-1:0]   r, rr;
    logic [OUT_W-1:0]        sat;

    // Accumulate, then bias, optional ReLU and clamp to the output range.
    always_comb begin
        s2_x    = (SIGNED != 0) ? ACC_W'($signed(s2)) : ACC_W'($signed({1'b0, s2}));
        acc_sum = (f2 ? '0 : acc) + s2_x;
        r       = {acc_sum[ACC_W-1], acc_sum} + {b2[ACC_W-1], b2};
        rr      = r;
        if (relu2 && rr < 0) rr = '0;
        if (rr > HI)      sat = HI[OUT_W-1:0];
        else if (rr < LO) sat = LO[OUT_W-1:0];
        else              sat = rr[OUT_W-1:0];
    end

    // Stage 3: keep the partial sum, or emit the result on the last channel.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc    <= '0;
            d_out  <= '0;
            en_out <= 1'b0;
        end else if (adv) begin
            en_out <= v2 & l2;
            if (v2) begin
                if (l2) begin
                    d_out <= sat;
                    acc   <= '0;
                end else begin
                    acc <= acc_sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_ch_accum.sv
// Bench for conv_ch_accum: an unsigned "*"/ripple instance and a signed
// full-adder/lookahead instance share one stimulus stream. A channel-level
// arithmetic model queues expected results; a monitor pops them on handshakes.
module tb_conv_ch_accum;
    localparam int ACC_W = 15;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [35:0]             data2conv, w;
    logic                    en_in, cfg_relu, out_ready;
    logic [2:0]              cfg_ch;
    logic signed [ACC_W-1:0] bias;
    logic                    in_ready_u, en_out_u, in_ready_s, en_out_s;
    logic [7:0]              d_out_u, d_out_s;

    conv_ch_accum #(.MULT(0), .useCLA(0), .SIGNED(0)) u_dut_u (
        .clk(clk), .rst(rst), .data2conv(data2conv), .w(w), .en_in(en_in),
        .in_ready(in_ready_u), .cfg_ch(cfg_ch), .cfg_relu(cfg_relu), .bias(bias),
        .d_out(d_out_u), .en_out(en_out_u), .out_ready(out_ready));

    conv_ch_accum #(.MULT(1), .useCLA(1), .SIGNED(1)) u_dut_s (
        .clk(clk), .rst(rst), .data2conv(data2conv), .w(w), .en_in(en_in),
        .in_ready(in_ready_s), .cfg_ch(cfg_ch), .cfg_relu(cfg_relu), .bias(bias),
        .d_out(d_out_s), .en_out(en_out_s), .out_ready(out_ready));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit bp_en  = 1'b0;

    logic [7:0] q_u[$];
    logic [7:0] q_s[$];
    int     m_cnt = 0;
    int     m_chn = 1;
    bit     m_relu;
    longint acc_u, acc_s;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s", nm);
    endtask

    function automatic logic [7:0] sat(input longint rin, input bit relu, input bit sgn);
        longint r;
        r = rin;
        if (relu && r < 0) r = 0;
        if (sgn) begin
            if (r > 127)  r = 127;
            if (r < -128) r = -128;
        end else begin
            if (r > 255) r = 255;
            if (r < 0)   r = 0;
        end
        return r[7:0];
    endfunction

    // Reference: per-output sum of dot products under both interpretations.
    task automatic model_beat(input logic [35:0] d, input logic [35:0] ww, input logic [2:0] ch,
                              input bit relu, input logic signed [ACC_W-1:0] b);
        logic [3:0] du, wu;
        if (m_cnt == 0) begin
            m_chn  = (ch == 0) ? 1 : ((ch > 4) ? 4 : int'(ch));
            m_relu = relu;
            acc_u  = 0;
            acc_s  = 0;
        end
        for (int i = 0; i < 9; i++) begin
            du = d[i*4 +: 4];
            wu = ww[i*4 +: 4];
            acc_u += longint'(du) * longint'(wu);
            acc_s += longint'($signed(du)) * longint'($signed(wu));
        end
        m_cnt++;
        if (m_cnt == m_chn) begin
            q_u.push_back(sat(acc_u + longint'(b), m_relu, 1'b0));
            q_s.push_back(sat(acc_s + longint'(b), m_relu, 1'b1));
            m_cnt = 0;
        end
    endtask

    // Monitor: compare on every output handshake.
    always @(negedge clk) begin
        if (rst) begin
            if (en_out_u && out_ready) begin
                if (q_u.size() == 0) fail("out_u unexpected result");
                else chk("out_u", longint'(d_out_u), longint'(q_u.pop_front()));
            end
            if (en_out_s && out_ready) begin
                if (q_s.size() == 0) fail("out_s unexpected result");
                else chk("out_s", longint'(d_out_s), longint'(q_s.pop_front()));
            end
        end
    end

    task automatic beat(input logic [35:0] d, input logic [35:0] ww, input logic [2:0] ch,
                        input bit relu, input logic signed [ACC_W-1:0] b);
        bit ok = 1'b0;
        data2conv = d; w = ww; cfg_ch = ch; cfg_relu = relu; bias = b; en_in = 1'b1;
        for (int g = 0; g < 200 && !ok; g++) begin
            @(negedge clk);
            if (in_ready_u) ok = 1'b1;
            else begin
                @(posedge clk); #1;
                if (bp_en) out_ready = ($urandom_range(0, 3) != 0);
            end
        end
        if (!ok) begin
            fail("beat accept timeout");
            en_in = 1'b0;
            return;
        end
        @(posedge clk); #1;
        model_beat(d, ww, ch, relu, b);
        en_in = 1'b0;
        if (bp_en) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle(input int n);
        en_in = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
            if (bp_en) out_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic drain();
        bp_en = 1'b0; out_ready = 1'b1; en_in = 1'b0;
        for (int g = 0; g < 100 && (q_u.size() != 0 || q_s.size() != 0); g++) begin
            @(posedge clk); #1;
        end
        if (q_u.size() != 0 || q_s.size() != 0) fail("drain timeout, results missing");
        idle(2);
    endtask

    function automatic logic [35:0] fill(input logic [3:0] v);
        return {9{v}};
    endfunction

    logic [35:0] ramp;
    logic [35:0] rd, rw;
    logic [2:0]  rch;
    bit          found;

    initial begin
        rst = 1'b0; en_in = 1'b0; data2conv = '0; w = '0; cfg_ch = '0;
        cfg_relu = 1'b0; bias = '0; out_ready = 1'b1;
        for (int i = 0; i < 9; i++) ramp[i*4 +: 4] = 4'(i + 1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        @(negedge clk);
        chk("rst en_out_u", en_out_u, 0);
        chk("rst d_out_u", d_out_u, 0);
        chk("rst in_ready_u", in_ready_u, 1);
        chk("rst en_out_s", en_out_s, 0);
        chk("rst d_out_s", d_out_s, 0);
        chk("rst in_ready_s", in_ready_s, 1);
        @(posedge clk); #1;

        // Single beat; result appears exactly three edges after the accept.
        beat(fill(4'd1), fill(4'd2), 3'd1, 1'b0, 15'sd0);
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            chk("latency en_out", en_out_u, (k == 3) ? 1 : 0);
        end
        @(posedge clk); #1;
        drain();

        // Four channels with negative bias.
        for (int j = 0; j < 4; j++) beat(ramp, fill(4'd1), 3'd4, 1'b0, -15'sd10);
        drain();

        // Saturation at the top of the output range.
        for (int j = 0; j < 4; j++) beat(fill(4'd15), fill(4'd15), 3'd4, 1'b0, 15'sd0);
        drain();

        // Negative result with and without ReLU.
        beat(fill(4'hF), fill(4'd3), 3'd1, 1'b1, 15'sd0);
        beat(fill(4'hF), fill(4'd3), 3'd1, 1'b0, 15'sd0);
        drain();

        // Downstream backpressure for five cycles while results are in flight.
        for (int j = 0; j < 3; j++)
            beat(36'({$urandom(), $urandom()}), 36'({$urandom(), $urandom()}), 3'd1, 1'b0, 15'sd0);
        en_in = 1'b0;
        out_ready = 1'b0;
        found = 1'b0;
        for (int g = 0; g < 10 && !found; g++) begin
            @(negedge clk);
            if (en_out_u) found = 1'b1;
        end
        if (!found) fail("stall: no result presented");
        else begin
            for (int k = 0; k < 5; k++) begin
                if (k > 0) @(negedge clk);
                chk("stall in_ready", in_ready_u, 0);
                chk("stall en_out", en_out_u, 1);
                if (q_u.size() == 0 || q_s.size() == 0) fail("stall: model queue empty");
                else begin
                    chk("stall d_out_u held", d_out_u, q_u[0]);
                    chk("stall d_out_s held", d_out_s, q_s[0]);
                end
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();

        // Random frames: config changes on non-first beats must be ignored,
        // bias is taken from the last beat, idle gaps and backpressure mixed in.
        bp_en = 1'b1;
        for (int o = 0; o < 30; o++) begin
            for (int j = 0; j < 8; j++) begin
                rd  = 36'({$urandom(), $urandom()});
                rw  = 36'({$urandom(), $urandom()});
                rch = 3'($urandom_range(0, 7));
                beat(rd, rw, rch, 1'($urandom_range(0, 1)), 15'($signed($urandom_range(0, 255)) - 128));
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                if (m_cnt == 0) break;
            end
        end
        drain();

        // Reset in the middle of an output discards the partial sum.
        for (int j = 0; j < 2; j++)
            beat(36'({$urandom(), $urandom()}), 36'({$urandom(), $urandom()}), 3'd4, 1'b0, 15'sd0);
        rst = 1'b0;
        m_cnt = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int j = 0; j < 4; j++) beat(fill(4'd1), fill(4'd1), 3'd4, 1'b0, 15'sd0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
